encoder_32_5_queue: RTL and testbench

Registered 32-to-5 request encoder: the inverse of the register-select decode path. Single-cycle request pulses on 32 one-hot lines are latched into a pending register. One pending index at a time is encoded to a 5-bit code and presented to a downstream consumer over a valid/ready handshake. Used wherever 32 distributed sources (e.g. per-register events, interrupt lines) must be serialized into a 5-bit index stream.

---
 rtl/encoder_32_5_queue.sv | 134 +++++++++++++
 tb/tb_encoder_32_5_queue.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_32_5_queue.sv
// encoder_32_5_queue: latches single-cycle pulses on 32 request lines into a
// pending register and serializes them as 5-bit codes over a valid/ready slot.
// Latency: req at edge k -> out_valid with that code after edge k+1 (2 cycles).
// Backpressure: out_valid && !out_ready holds the slot stable, and no pending bit is cleared.
//
// Ports:
//   clock      - single clock, rising edge
//   reset      - asynchronous, active-low; clears all state immediately
//   req[31:0]  - request pulses; bit i sets pending[i]
//   mask[31:0] - bit i low hides pending[i] from selection without clearing it
//   out_ready  - consumer accepts out_code when high together with out_valid
//   out_valid  - out_code holds a valid index
//   out_code   - encoded index of the granted request
//   pending    - pending register (after this cycle's grant clear)
//   overrun    - sticky; a req bit arrived while that bit was already pending
//
// Optional feature macro: ENC_ROUND_ROBIN_EN
//   defined   : round-robin selection starting just after the last granted index
//   undefined : fixed priority, lowest eligible index wins

module encoder_32_5_queue (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] req,
  input  logic [31:0] mask,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [4:0]  out_code,
  output logic [31:0] pending,
  output logic        overrun
);

  logic [31:0] pending_q, pending_d;
  logic        out_valid_q, out_valid_d;
  logic [4:0]  out_code_q, out_code_d;
  logic        overrun_q, overrun_d;

  logic [31:0] eligible;
  logic [31:0] grant_onehot;
  logic        slot_free;
  logic        sel_found;
  logic [4:0]  sel_idx;

`ifdef ENC_ROUND_ROBIN_EN
  logic [4:0]  last_grant_q, last_grant_d;
  logic [4:0]  cand;
`endif

  assign eligible  = pending_q & mask;
  assign slot_free = !out_valid_q || out_ready;

  // Index selection
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 5'd0;
`ifdef ENC_ROUND_ROBIN_EN
    cand      = 5'd0;
    // Scan from last_grant+1 upward; the 5-bit add wraps 31->0 and the last
    // candidate (offset 32) is last_grant itself.
    for (int i = 0; i < 32; i++) begin
      cand = last_grant_q + 5'(i + 1);
      if (!sel_found && eligible[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
`else
    // Descending scan so the lowest set index is the final assignment.
    for (int i = 31; i >= 0; i--) begin
      if (eligible[i]) begin
        sel_found = 1'b1;
        sel_idx   = 5'(i);
      end
    end
`endif
  end

  // Slot, pending and overrun next state
  always_comb begin
    grant_onehot = 32'd0;
    out_valid_d  = out_valid_q;
    out_code_d   = out_code_q;
    if (slot_free) begin
      if (sel_found) begin
        out_valid_d  = 1'b1;
        out_code_d   = sel_idx;
        grant_onehot = 32'd1 << sel_idx;
      end else begin
        out_valid_d  = 1'b0;
      end
    end
    // Set wins over clear: a req on the granted bit leaves it pending.
    pending_d = (pending_q & ~grant_onehot) | req;
    // A req on the bit being granted this edge is a fresh request, not a duplicate.
    overrun_d = overrun_q | (|(req & pending_q & ~grant_onehot));
  end

`ifdef ENC_ROUND_ROBIN_EN
  always_comb begin
    last_grant_d = last_grant_q;
    if (slot_free && sel_found) begin
      last_grant_d = sel_idx;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant_q <= 5'd31;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_q   <= 32'd0;
      out_valid_q <= 1'b0;
      out_code_q  <= 5'd0;
      overrun_q   <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign pending   = pending_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_encoder_32_5_queue.sv
module tb_encoder_32_5_queue;

  logic        clock;
  logic        reset;
  logic [31:0] req;
  logic [31:0] mask;
  logic        out_ready;
  logic        out_valid;
  logic [4:0]  out_code;
  logic [31:0] pending;
  logic        overrun;

  int errors;
  int checks;
  int exp_q[$];

  encoder_32_5_queue dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .mask      (mask),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_code  (out_code),
    .pending   (pending),
    .overrun   (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one edge; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Wait until every pushed code has been observed, then let the slot settle.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 64) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d codes outstanding expected 0", name, exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  // Monitor: a transfer occurs at the next rising edge when valid && ready.
  always @(negedge clock) begin
    if (reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_code: got %0d expected no output", out_code);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(out_code) != e) begin
          errors++;
          $display("FAIL code: got %0d expected %0d", out_code, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b0;
    req       = 32'd0;
    mask      = 32'hFFFF_FFFF;
    out_ready = 1'b1;
    #2;
    check("rst_valid",   32'(out_valid), 32'd0);
    check("rst_code",    32'(out_code),  32'd0);
    check("rst_pending", pending,        32'd0);
    check("rst_overrun", 32'(overrun),   32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Two requests in one pulse: codes 0 then 31 back to back.
    exp_q.push_back(0);
    exp_q.push_back(31);
    req = 32'h8000_0001;
    tick();
    req = 32'd0;
    check("t2_pending_set", pending, 32'h8000_0001);
    drain("t2");
    check("t2_valid_off", 32'(out_valid), 32'd0);
    check("t2_pending",   pending,        32'd0);

    // Stall: code 1 held stable while not ready, then 1, 2.
    out_ready = 1'b0;
    req = 32'h0000_0006;
    tick();
    req = 32'd0;
    tick();
    tick();
    tick();
    check("t3_hold_valid",   32'(out_valid), 32'd1);
    check("t3_hold_code",    32'(out_code),  32'd1);
    check("t3_hold_pending", pending,        32'h0000_0004);
    exp_q.push_back(1);
    exp_q.push_back(2);
    out_ready = 1'b1;
    drain("t3");
    check("t3_valid_off", 32'(out_valid), 32'd0);

    // req[5] re-pulsed on its grant edge: two grants, no overrun.
    exp_q.push_back(5);
    exp_q.push_back(5);
    req = 32'h0000_0020;
    tick();
    tick();
    req = 32'd0;
    drain("t4a");
    check("t4_no_overrun", 32'(overrun), 32'd0);

    // Duplicate while pending and slot stalled: overrun sets.
    out_ready = 1'b0;
    req = 32'h0000_0020;
    tick();
    req = 32'd0;
    tick();
    req = 32'h0000_0020;
    tick();
    check("t4_no_overrun_yet", 32'(overrun), 32'd0);
    tick();
    req = 32'd0;
    check("t4_overrun", 32'(overrun), 32'd1);
    exp_q.push_back(5);
    exp_q.push_back(5);
    out_ready = 1'b1;
    drain("t4b");
    check("t4_overrun_sticky", 32'(overrun), 32'd1);

    // Mask hides bit 0 until it is unmasked.
    mask = 32'hFFFF_FFFE;
    exp_q.push_back(1);
    req = 32'h0000_0003;
    tick();
    req = 32'd0;
    drain("t5a");
    tick();
    check("t5_masked_pending", pending,        32'h0000_0001);
    check("t5_masked_valid",   32'(out_valid), 32'd0);
    exp_q.push_back(0);
    mask = 32'hFFFF_FFFF;
    drain("t5b");
    check("t5_pending_clear", pending, 32'd0);

    // Reset mid-stream with pending F0 and a code in the slot.
    out_ready = 1'b0;
    req = 32'h0000_00F0;
    tick();
    req = 32'd0;
    tick();
    req = 32'h0000_0010;
    tick();
    req = 32'd0;
    check("t1_pre_pending", pending,        32'h0000_00F0);
    check("t1_pre_valid",   32'(out_valid), 32'd1);
    reset = 1'b0;
    #1;
    check("t1_rst_valid",   32'(out_valid), 32'd0);
    check("t1_rst_code",    32'(out_code),  32'd0);
    check("t1_rst_pending", pending,        32'd0);
    check("t1_rst_overrun", 32'(overrun),   32'd0);
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("t1_post_valid", 32'(out_valid), 32'd0);

    // Continuous req 0x13: rotation with round robin, else code 0 every time.
`ifdef ENC_ROUND_ROBIN_EN
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(4);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(4);
`else
    for (int i = 0; i < 6; i++) exp_q.push_back(0);
`endif
    req = 32'h0000_0013;
    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 64) begin
        tick();
        n++;
      end
      out_ready = 1'b0;
      req = 32'd0;
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL t6_drain: got %0d codes outstanding expected 0", exp_q.size());
        exp_q.delete();
      end
    end
    tick();
    check("t6_pending", pending, 32'h0000_0013);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
